sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
- REQ-001: Parameter WAIT_CYCLES, default 5: cycles of each SRAM access phase. Legal range 1..15.
- REQ-002: Parameter BASE_ADDR, default 1024: CPU byte address that maps to SRAM word 0.
- REQ-003: clk  input  1: single clock; all state updates on rising edge.
- REQ-004: rst  input  1: asynchronous, active-high reset.
- REQ-005: wr_en  input  1: MEM-stage store request.
- REQ-006: rd_en  input  1: MEM-stage load request.
- REQ-007: address  input  32: CPU byte address, word-aligned.
- REQ-008: write_data  input  32: store data.
- REQ-009: read_data  output  32: load result.
- REQ-010: ready  output  1: low means the pipeline shall freeze.
- REQ-011: SRAM_DQ  inout  64: SRAM data bus.
- REQ-012: SRAM_ADDR  output  17: SRAM 64-bit word address.
- REQ-013: SRAM_WE_N  output  1: SRAM write strobe, active-low.

Function
- REQ-014: Address mapping: off = address - BASE_ADDR, modulo 2^32.
  - SRAM_ADDR = off[19:3]; higher bits are dropped, so the address wraps.
  - off[2] selects the half: 0 = DQ[31:0], 1 = DQ[63:32].
- REQ-015: FSM states: IDLE, RD, WR_RD, WR_WR, DONE. Wait counter is 4 bits.
- REQ-016: IDLE with wr_en=1 -> WR_RD. IDLE with rd_en=1 and wr_en=0 -> RD. Counter cleared on each transition.
- REQ-017: Accept cycle: in IDLE, address and write_data are registered when a request is accepted. Later changes to the inputs are ignored until DONE.
- REQ-018: RD phase:
  - lasts exactly WAIT_CYCLES cycles;
  - SRAM_ADDR is held;
  - SRAM_WE_N = 1;
  - DQ is high-Z.
  On its last cycle, the selected 32-bit half of SRAM_DQ is latched into read_data and the FSM goes to DONE.
- REQ-019: WR_RD phase (read-modify-write): identical to RD, except the full 64-bit SRAM_DQ is latched into a merge buffer, then the FSM goes to WR_WR.
- REQ-020: WR_WR phase:
  - lasts WAIT_CYCLES cycles;
  - SRAM_WE_N = 0;
  - SRAM_DQ drives the merge buffer with the selected half replaced by write_data;
  - the other half is unchanged.
  Afterwards -> DONE.
- REQ-021: DONE lasts 1 cycle, then -> IDLE unconditionally. A request still asserted in the following IDLE cycle starts a new transaction.
- REQ-022: ready = ~(rd_en | wr_en) when in IDLE; 0 in RD/WR_RD/WR_WR; 1 in DONE. It is combinational from state and inputs.
- REQ-023: Latency measured from the accept cycle (cycle 0): ready is high in cycle WAIT_CYCLES+1 for loads and 2*WAIT_CYCLES+1 for stores.
- REQ-024: SRAM_DQ is driven only in WR_WR; it is high-Z in all other states.
- REQ-025: SRAM_WE_N is 1 in every state except WR_WR.
- REQ-026: read_data holds its last loaded value. Stores do not alter it.
- REQ-027: If rd_en and wr_en are asserted together, the request is treated as a store.
- REQ-028: Request inputs are ignored outside IDLE, including toggles mid-transaction.

Reset
- REQ-029: rst asserted at any time, including mid-RD or mid-WR_WR, immediately sets:
  - state = IDLE;
  - counter = 0;
  - SRAM_WE_N = 1;
  - SRAM_DQ high-Z;
  - SRAM_ADDR = 0;
  - read_data = 0;
  - merge buffer = 0.
- REQ-030: After rst deasserts, ready reflects REQ-022. No partial write shall resume.

Verification
- REQ-031: Reset idle. Hold rst, then release with no request -> ready=1, SRAM_WE_N=1, DQ=Z, read_data=0.
- REQ-032: Store then load.
  - Store 0xDEADBEEF to 1028 -> SRAM_ADDR=0, WE_N low for 5 cycles, DQ[63:32]=0xDEADBEEF with DQ[31:0] preserved, ready high at cycle 11.
  - Then load 1028 -> read_data=0xDEADBEEF, ready high at cycle 6.
- REQ-033: Half merge. Store 0x11111111 to 1024, then 0x22222222 to 1028 -> word 0 = 0x22222222_11111111. Loads of both addresses return their own values.
- REQ-034: Simultaneous requests. rd_en=wr_en=1 at 1032 with 0xA5A5A5A5 -> store path taken (WE_N pulses) and read_data is unchanged.
- REQ-035: Reset mid-write. Assert rst in the 2nd WR_WR cycle -> WE_N=1 and DQ=Z at once, state IDLE. A later load may return the old or the new word but never X.
- REQ-036: Wrap. Load address BASE_ADDR + 0x100000 -> SRAM_ADDR=0. Load with WAIT_CYCLES=1 -> ready high at cycle 2.

Source files
------------

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Connects a CPU MEM stage to a 64-bit asynchronous SRAM.
//               A 32-bit load reads one SRAM word and returns one half of it.
//               A 32-bit store does a read-modify-write: it reads the whole
//               word, replaces one half, and writes the word back.
//               ready stays low while an access is in progress, so the
//               pipeline freezes until the access completes.
// Ports       : clk, rst          - clock and async active-high reset
//               wr_en, rd_en      - store / load request (a store wins if both)
//               address           - CPU byte address (word aligned)
//               write_data        - store data
//               read_data         - last load result
//               ready             - low = pipeline must stall
//               SRAM_DQ           - bidirectional 64-bit SRAM data bus
//               SRAM_ADDR         - SRAM 64-bit word address
//               SRAM_WE_N         - SRAM write strobe, active low
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter int          WAIT_CYCLES = 5,       // legal range 1..15
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [63:0] SRAM_DQ,
    output logic [16:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR_RD = 3'd2,
        S_WR_WR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The counter value on the last cycle of each access phase.
    localparam logic [3:0] c_last = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_half;
    logic [31:0] r_wdata;
    logic [63:0] r_merge;
    logic [31:0] r_read_data;
    logic [16:0] r_sram_addr;

    logic [31:0] w_off;
    logic        w_req;
    logic        w_last;
    logic [63:0] w_wr_word;
    logic        w_unused;

    // The offset subtraction wraps modulo 2^32. Bits above 19 are dropped,
    // so the SRAM window repeats every 1 MiB.
    assign w_off    = address - BASE_ADDR;
    assign w_unused = ^{w_off[31:20], w_off[1:0]};
    assign w_req    = rd_en | wr_en;
    assign w_last   = (r_cnt == c_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and ready
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = ~w_req;
                // A store takes priority over a simultaneous load.
                if (wr_en) begin
                    w_state_nxt = S_WR_RD;
                    w_cnt_nxt   = 4'd0;
                end else if (rd_en) begin
                    w_state_nxt = S_RD;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_RD: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_WR_RD: begin
                if (w_last) begin
                    w_state_nxt = S_WR_WR;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_WR_WR: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                ready       = 1'b1;
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture, read latch, merge buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sram_addr <= 17'd0;
            r_half      <= 1'b0;
            r_wdata     <= 32'd0;
            r_merge     <= 64'd0;
            r_read_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Capture the request once. Later input changes are
                    // ignored until the access is finished.
                    if (w_req) begin
                        r_sram_addr <= w_off[19:3];
                        r_half      <= w_off[2];
                        r_wdata     <= write_data;
                    end
                end
                S_RD: begin
                    if (w_last) begin
                        r_read_data <= r_half ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
                    end
                end
                S_WR_RD: begin
                    if (w_last) begin
                        r_merge <= SRAM_DQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-back word: the addressed half is replaced, the other half is kept.
    assign w_wr_word = r_half ? {r_wdata, r_merge[31:0]}
                              : {r_merge[63:32], r_wdata};

    // The strobe and the bus drive come straight from the state register,
    // so an asynchronous reset releases both at once.
    assign SRAM_WE_N = (r_state != S_WR_WR);
    assign SRAM_DQ   = (r_state == S_WR_WR) ? w_wr_word : 64'bz;
    assign SRAM_ADDR = r_sram_addr;
    assign read_data = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller. It contains a
//               behavioural SRAM and a 32-bit word reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [63:0] sram_dq;
    logic [16:0] sram_addr;
    logic        sram_we_n;

    // Second instance with WAIT_CYCLES = 1.
    logic        rd1, wr1;
    logic [31:0] addr1;
    logic [31:0] wd1;
    logic [31:0] rdata1;
    logic        ready1;
    wire  [63:0] sram_dq1;
    logic [16:0] sram_addr1;
    logic        we_n1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(sram_we_n)
    );

    sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1),
        .address(addr1), .write_data(wd1), .read_data(rdata1),
        .ready(ready1), .SRAM_DQ(sram_dq1), .SRAM_ADDR(sram_addr1),
        .SRAM_WE_N(we_n1)
    );

    // Behavioural asynchronous SRAM: it drives the bus while WE_N is high
    // and stores the bus value on each clock while WE_N is low.
    logic [63:0] mem [0:131071];
    assign sram_dq  = sram_we_n ? mem[sram_addr] : 64'bz;
    assign sram_dq1 = we_n1 ? 64'hCAFE0001_0BAD0002 : 64'bz;
    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

    // Reference model: a flat array of 32-bit words, indexed by the
    // (byte offset / 4) that wraps at 1 MiB.
    logic [31:0] ref32 [logic [17:0]];

    function automatic logic [17:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[19:2];
    endfunction

    function automatic logic [31:0] init32(input logic [17:0] i);
        return ({14'd0, i} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_get(input logic [17:0] i);
        if (ref32.exists(i)) return ref32[i];
        return init32(i);
    endfunction

    // Runs one transaction on the main instance. The first negedge after the
    // call is the accept cycle (cycle 0). Inputs are scrambled in cycle 1 so
    // that mid-transaction toggles are exercised. lat = -1 on timeout.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output int we_cnt,
                          output logic [63:0] dq_w, output logic [16:0] sa);
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        lat = -1; we_cnt = 0; dq_w = 64'd0; sa = 17'd0;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                sa         = sram_addr;
                address    = $urandom;
                write_data = $urandom;
                rd_en      = 1'($urandom);
                wr_en      = 1'($urandom);
            end
            if (!sram_we_n) begin
                we_cnt++;
                dq_w = sram_dq;
            end
            if (ready) begin
                lat   = k;
                rd_en = 1'b0;
                wr_en = 1'b0;
            end
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
        n_tests++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
        n_tests++; if (sram_addr !== 17'd0) begin n_fail++; $display("FAIL reset_sram_addr got=%h exp=0", sram_addr); end
        n_tests++; if (sram_dq !== mem[0]) begin n_fail++; $display("FAIL reset_dq_released got=%h exp=%h", sram_dq, mem[0]); end
    endtask

    task automatic test_store_load;
        int lat, wc; logic [63:0] dq; logic [16:0] sa; logic [63:0] exp_dq;
        exp_dq = {32'hDEADBEEF, ref_get(18'd0)};
        do_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lat, wc, dq, sa);
        ref32[widx(32'd1028)] = 32'hDEADBEEF;
        n_tests++; if (lat != 2*W+1) begin n_fail++; $display("FAIL store_latency got=%0d exp=%0d", lat, 2*W+1); end
        n_tests++; if (wc != W) begin n_fail++; $display("FAIL store_we_cycles got=%0d exp=%0d", wc, W); end
        n_tests++; if (sa !== 17'd0) begin n_fail++; $display("FAIL store_sram_addr got=%h exp=0", sa); end
        n_tests++; if (dq !== exp_dq) begin n_fail++; $display("FAIL store_dq got=%h exp=%h", dq, exp_dq); end
        n_tests++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL store_keeps_read_data got=%h exp=0", read_data); end
        do_txn(1'b1, 1'b0, 32'd1028, 32'd0, lat, wc, dq, sa);
        n_tests++; if (lat != W+1) begin n_fail++; $display("FAIL load_latency got=%0d exp=%0d", lat, W+1); end
        n_tests++; if (wc != 0) begin n_fail++; $display("FAIL load_we_cycles got=%0d exp=0", wc); end
        n_tests++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data got=%h exp=deadbeef", read_data); end
    endtask

    task automatic test_half_merge;
        int lat, wc; logic [63:0] dq; logic [16:0] sa;
        do_txn(1'b0, 1'b1, 32'd1024, 32'h11111111, lat, wc, dq, sa);
        ref32[widx(32'd1024)] = 32'h11111111;
        do_txn(1'b0, 1'b1, 32'd1028, 32'h22222222, lat, wc, dq, sa);
        ref32[widx(32'd1028)] = 32'h22222222;
        n_tests++; if (mem[0] !== 64'h22222222_11111111) begin n_fail++; $display("FAIL merge_word got=%h exp=2222222211111111", mem[0]); end
        do_txn(1'b1, 1'b0, 32'd1024, 32'd0, lat, wc, dq, sa);
        n_tests++; if (read_data !== 32'h11111111) begin n_fail++; $display("FAIL merge_load_lo got=%h exp=11111111", read_data); end
        do_txn(1'b1, 1'b0, 32'd1028, 32'd0, lat, wc, dq, sa);
        n_tests++; if (read_data !== 32'h22222222) begin n_fail++; $display("FAIL merge_load_hi got=%h exp=22222222", read_data); end
    endtask

    task automatic test_simultaneous;
        int lat, wc; logic [63:0] dq; logic [16:0] sa; logic [31:0] prev;
        prev = read_data;
        do_txn(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, lat, wc, dq, sa);
        ref32[widx(32'd1032)] = 32'hA5A5A5A5;
        n_tests++; if (wc != W) begin n_fail++; $display("FAIL simul_we_cycles got=%0d exp=%0d", wc, W); end
        n_tests++; if (lat != 2*W+1) begin n_fail++; $display("FAIL simul_latency got=%0d exp=%0d", lat, 2*W+1); end
        n_tests++; if (read_data !== prev) begin n_fail++; $display("FAIL simul_read_data got=%h exp=%h", read_data, prev); end
        n_tests++; if (mem[1][31:0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL simul_sram got=%h exp=a5a5a5a5", mem[1][31:0]); end
    endtask

    task automatic test_reset_mid_write;
        int lat, wc; logic [63:0] dq; logic [16:0] sa; logic [31:0] old_v, new_v;
        old_v = ref_get(widx(32'd1036));
        new_v = 32'h0F0F1234;
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1036; write_data = new_v;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (k == 1) wr_en = 1'b0;
        end
        n_tests++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_write got=%b exp=0", sram_we_n); end
        rst = 1'b1;
        #1;
        n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_we_n got=%b exp=1", sram_we_n); end
        n_tests++; if (sram_addr !== 17'd0) begin n_fail++; $display("FAIL rstmid_sram_addr got=%h exp=0", sram_addr); end
        n_tests++; if (sram_dq !== mem[0]) begin n_fail++; $display("FAIL rstmid_dq_released got=%h exp=%h", sram_dq, mem[0]); end
        n_tests++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_read_data got=%h exp=0", read_data); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=1", ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_no_resume got=%b exp=1", sram_we_n); end
        do_txn(1'b1, 1'b0, 32'd1036, 32'd0, lat, wc, dq, sa);
        n_tests++;
        if ($isunknown(read_data) || (read_data !== old_v && read_data !== new_v)) begin
            n_fail++; $display("FAIL rstmid_load got=%h exp=%h or %h", read_data, old_v, new_v);
        end
        ref32[widx(32'd1036)] = read_data;
    endtask

    task automatic test_wrap;
        int lat, wc; logic [63:0] dq; logic [16:0] sa; logic [31:0] a;
        a = BASE + 32'h0010_0000;
        do_txn(1'b1, 1'b0, a, 32'd0, lat, wc, dq, sa);
        n_tests++; if (sa !== 17'd0) begin n_fail++; $display("FAIL wrap_sram_addr got=%h exp=0", sa); end
        n_tests++; if (read_data !== ref_get(widx(a))) begin n_fail++; $display("FAIL wrap_data got=%h exp=%h", read_data, ref_get(widx(a))); end
    endtask

    task automatic test_wait1;
        int lat;
        @(negedge clk);
        rd1 = 1'b1; addr1 = BASE + 32'd4;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) rd1 = 1'b0;
            if (ready1) lat = k;
        end
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL w1_latency got=%0d exp=2", lat); end
        n_tests++; if (rdata1 !== 32'hCAFE0001) begin n_fail++; $display("FAIL w1_data got=%h exp=cafe0001", rdata1); end
    endtask

    task automatic test_random;
        int lat, wc; logic [63:0] dq; logic [16:0] sa;
        logic [31:0] a, d, prev; logic rd, wr;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       a = BASE + 32'h0010_0000 + (32'($urandom_range(0, 15)) << 2);
                1:       a = BASE - (32'($urandom_range(1, 8)) << 2);
                default: a = BASE + (32'($urandom_range(0, 15)) << 2);
            endcase
            d    = $urandom;
            wr   = 1'($urandom);
            rd   = wr ? 1'($urandom) : 1'b1;
            prev = read_data;
            do_txn(rd, wr, a, d, lat, wc, dq, sa);
            if (wr) begin
                ref32[widx(a)] = d;
                n_tests++; if (lat != 2*W+1 || wc != W) begin n_fail++; $display("FAIL rand_store it=%0d lat=%0d we=%0d exp=%0d/%0d", it, lat, wc, 2*W+1, W); end
                n_tests++; if (read_data !== prev) begin n_fail++; $display("FAIL rand_store_rd it=%0d got=%h exp=%h", it, read_data, prev); end
            end else begin
                n_tests++; if (lat != W+1) begin n_fail++; $display("FAIL rand_load_lat it=%0d got=%0d exp=%0d", it, lat, W+1); end
                n_tests++; if (read_data !== ref_get(widx(a))) begin n_fail++; $display("FAIL rand_load it=%0d addr=%h got=%h exp=%h", it, a, read_data, ref_get(widx(a))); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++)
            mem[i] = {init32({17'(i), 1'b1}), init32({17'(i), 1'b0})};
        test_reset;
        test_store_load;
        test_half_merge;
        test_simultaneous;
        test_reset_mid_write;
        test_wrap;
        test_wait1;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
